// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and iteration-counter sizing.
package div32_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div32_seq_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] trial;

  // rem < divisor always holds, so trial's top bit is a clean sign flag.
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div32_seq.sv
// Sequential unsigned divider, one quotient bit per clock, with a
// ready/valid handshake on both sides and single-edge divide-by-zero path.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs_q, quo_q, rem_q;
  logic [WIDTH-1:0] quo_step, rem_step;
  logic             dbz_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_step),
    .quo_nxt (quo_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:  if (cnt == CW'(1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Quotient register doubles as the dividend shift register during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quo_q <= '1;
              rem_q <= dividend;
              dbz_q <= 1'b1;
            end else begin
              dvs_q <= divisor;
              quo_q <= dividend;
              rem_q <= '0;
              cnt   <= CW'(WIDTH);
              dbz_q <= 1'b0;
            end
          end
        end
        RUN: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          cnt   <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Scoreboard bench for div32_seq: directed corner cases, back-pressure,
// mid-run reset and a randomized back-to-back stream.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];

  div32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: plain language division, independent of the bit-serial algorithm.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Present operands until accepted; operands are scrambled right after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL issue_accept: in_ready=%0b required 1", in_ready);
    end
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Pop the scoreboard, compare the presented result, hand it off, confirm return to IDLE.
  task automatic consume(input string tag);
    exp_t e;
    logic [63:0] recon;
    n_checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: out_valid=%0b pending=%0d required valid result", tag, out_valid, sb.size());
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (quotient !== e.q) begin
      n_fail++;
      $display("FAIL %s_quotient: %0d/%0d got 0x%08h required 0x%08h", tag, e.a, e.b, quotient, e.q);
    end
    n_checks++;
    if (remainder !== e.r) begin
      n_fail++;
      $display("FAIL %s_remainder: %0d/%0d got 0x%08h required 0x%08h", tag, e.a, e.b, remainder, e.r);
    end
    n_checks++;
    if (div_by_zero !== e.z) begin
      n_fail++;
      $display("FAIL %s_dbz: %0d/%0d got %0b required %0b", tag, e.a, e.b, div_by_zero, e.z);
    end
    if (e.b != 0) begin
      recon = {32'd0, quotient} * {32'd0, e.b} + {32'd0, remainder};
      n_checks++;
      if (recon !== {32'd0, e.a} || remainder >= e.b) begin
        n_fail++;
        $display("FAIL %s_identity: q*b+r=%0d r=%0d required a=%0d r<%0d", tag, recon, remainder, e.a, e.b);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_handoff: out_valid=%0b in_ready=%0b required 0 1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'd0 ||
        remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%0b vld=%0b q=%0h r=%0h z=%0b required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int n;
    issue(32'd100, 32'd7);
    wait_valid(n);
    n_checks++;
    if (n != 32) begin
      n_fail++;
      $display("FAIL basic_latency: %0d edges required 32", n);
    end
    consume("basic");
  endtask

  task automatic test_div_zero();
    int n;
    issue(32'h1234_5678, 32'd0);
    wait_valid(n);
    n_checks++;
    if (n != 0) begin
      n_fail++;
      $display("FAIL dbz_latency: %0d extra edges required 0", n);
    end
    consume("dbz");
  endtask

  task automatic test_boundaries();
    logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    logic [31:0] vb [6] = '{32'd1, 32'd10, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    int n;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i]);
      wait_valid(n);
      consume("boundary");
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] hq, hr;
    logic        hz;
    issue(32'd1000, 32'd7);
    wait_valid(n);
    hq = quotient;
    hr = remainder;
    hz = div_by_zero;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start    = i[0];
      dividend = $urandom;
      divisor  = $urandom_range(0, 3);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== hq ||
          remainder !== hr || div_by_zero !== hz) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: vld=%0b rdy=%0b q=%0d r=%0d z=%0b required 1 0 %0d %0d %0b",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero, hq, hr, hz);
      end
    end
    @(negedge clk);
    start = 1'b0;
    consume("hold");
  endtask

  task automatic test_reset_midrun();
    int n;
    bit saw_valid = 0;
    issue(32'd1000, 32'd3);
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 32'd0 ||
        remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: rdy=%0b vld=%0b q=%0h r=%0h z=%0b required 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1;
    end
    n_checks++;
    if (saw_valid) begin
      n_fail++;
      $display("FAIL abort_no_result: out_valid seen=1 required 0");
    end
    issue(32'd1000, 32'd3);
    wait_valid(n);
    consume("after_abort");
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] a, b;
    int sel;
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 15);
      a = (sel < 3) ? 32'($urandom_range(0, 1000)) : $urandom;
      if (sel == 0)      b = 32'd0;
      else if (sel < 6)  b = 32'($urandom_range(1, 255));
      else if (sel == 6) b = 32'd1;
      else               b = $urandom >> $urandom_range(0, 31);
      issue(a, b);
      wait_valid(n);
      n_checks++;
      if (n != ((b == 0) ? 0 : 32)) begin
        n_fail++;
        $display("FAIL rand_latency: %0d/%0d took %0d edges required %0d", a, b, n, (b == 0) ? 0 : 32);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      consume("rand");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_boundaries();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
